// File: rtl/pio_gen2_pkg.sv
// rtl/pio_gen2_pkg.sv - shared register map and edge-mode encodings for the PIO block
package pio_gen2_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // One bit of edge detection: cur is the newest synchronised sample, prev the one before.
    function automatic logic edge_hit(input logic cur, input logic prev, input int edge_type);
        case (edge_type)
            EDGE_RISING:  return cur & ~prev;
            EDGE_FALLING: return ~cur & prev;
            default:      return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// rtl/pio_sync_chain.sv - multi-flop synchroniser for asynchronous pin inputs
module pio_sync_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the pin sample one stage per clock; all stages clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pio_ctrl_gen2.sv
// rtl/pio_ctrl_gen2.sv - Avalon-MM parallel I/O port with direction, set/clear and edge interrupts
module pio_ctrl_gen2
    import pio_gen2_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    // Edges are only trusted once the delay flop holds a real post-reset pin sample.
    localparam int FILL_CYCLES = SYNC_STAGES + 1;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [DATA_WIDTH-1:0] sync_dly_q;
    logic [2:0]            fill_q, fill_d;

    logic [DATA_WIDTH-1:0] sync_w;
    logic [DATA_WIDTH-1:0] edge_w;
    logic [DATA_WIDTH-1:0] cap_clr_w;
    logic [DATA_WIDTH-1:0] wdata_w;
    logic [DATA_WIDTH-1:0] rd_val_w;
    logic                  wr_en_w;
    logic                  rd_en_w;
    logic                  fill_done_w;
    logic                  unused_wdata;

    pio_sync_chain #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (sync_w)
    );

    assign wr_en_w      = chipselect & ~write_n;
    assign rd_en_w      = chipselect & write_n;
    assign wdata_w      = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign fill_done_w  = (fill_q == 3'(FILL_CYCLES));

    // Per-bit edge detection between the last synchroniser stage and its delayed copy.
    always_comb begin
        edge_w = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            edge_w[i] = fill_done_w & edge_hit(sync_w[i], sync_dly_q[i], EDGE_TYPE);
        end
    end

    // Register-file next state; a capture in the same cycle as a clear wins.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_mask_d = irq_mask_q;
        cap_clr_w  = '0;
        if (wr_en_w) begin
            case (address)
                ADDR_DATA:     data_out_d = wdata_w;
                ADDR_DIR:      dir_d      = wdata_w;
                ADDR_IRQ_MASK: irq_mask_d = wdata_w;
                ADDR_EDGE_CAP: cap_clr_w  = wdata_w;
                ADDR_OUTSET:   data_out_d = data_out_q | wdata_w;
                ADDR_OUTCLR:   data_out_d = data_out_q & ~wdata_w;
                default:       ;
            endcase
        end
        edge_cap_d = (edge_cap_q & ~cap_clr_w) | edge_w;
        fill_d     = fill_done_w ? fill_q : fill_q + 3'd1;
    end

    // State registers, including the edge-detector delay flop and the post-reset fill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            sync_dly_q <= '0;
            fill_q     <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            sync_dly_q <= sync_w;
            fill_q     <= fill_d;
        end
    end

    // Zero-latency read mux; idle bus reads as zero.
    always_comb begin
        rd_val_w = '0;
        if (rd_en_w) begin
            case (address)
                ADDR_DATA:     rd_val_w = (data_out_q & dir_q) | (sync_w & ~dir_q);
                ADDR_DIR:      rd_val_w = dir_q;
                ADDR_IRQ_MASK: rd_val_w = irq_mask_q;
                ADDR_EDGE_CAP: rd_val_w = edge_cap_q;
                default:       rd_val_w = '0;
            endcase
        end
    end

    assign readdata = 32'(rd_val_w);
    assign out_port = data_out_q;
    assign oe_port  = dir_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_ctrl_gen2.sv
// tb/tb_pio_ctrl_gen2.sv - self-checking bench for pio_ctrl_gen2 against a pin-history model
module tb_pio_ctrl_gen2;

    localparam int         S  = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_dout, m_dir, m_mask, m_cap;
    logic [7:0] hist[$];

    always #5 clk = ~clk;

    pio_ctrl_gen2 #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (RV),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    function automatic logic [7:0] m_sync();
        if (hist.size() >= S) return hist[hist.size()-S];
        return 8'h00;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, (m_dout & m_dir) | (m_sync() & ~m_dir)};
            3'd1:    return {24'h0, m_dir};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq();
        return |(m_cap & m_mask);
    endfunction

    task automatic model_reset();
        m_dout = RV;
        m_dir  = 8'h00;
        m_mask = 8'h00;
        m_cap  = 8'h00;
        hist.delete();
    endtask

    // One clock edge of the reference: a rising edge is captured once the pin was seen low then high
    // S+1 and S samples ago, and only if both samples were taken after reset release.
    task automatic model_step();
        logic [7:0] clr;
        logic [7:0] edges;
        int n;
        clr   = 8'h00;
        edges = 8'h00;
        if (!reset_n) begin
            model_reset();
            return;
        end
        hist.push_back(in_port);
        n = hist.size();
        if (n >= S + 2) edges = hist[n-S-1] & ~hist[n-S-2];
        if (chipselect && !write_n) begin
            case (address)
                3'd0: m_dout = writedata[7:0];
                3'd1: m_dir  = writedata[7:0];
                3'd2: m_mask = writedata[7:0];
                3'd3: clr    = writedata[7:0];
                3'd4: m_dout = m_dout | writedata[7:0];
                3'd5: m_dout = m_dout & ~writedata[7:0];
                default: ;
            endcase
        end
        m_cap = (m_cap & ~clr) | edges;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        model_reset();
        ticks(3);
        checks++; if (out_port !== RV) begin errors++; $display("FAIL reset_out_port got %h want %h", out_port, RV); end
        checks++; if (oe_port !== 8'h00) begin errors++; $display("FAIL reset_oe_port got %h want 00", oe_port); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            checks++;
            if (d !== m_read(3'(a))) begin
                errors++; $display("FAIL reset_read_%0d got %h want %h", a, d, m_read(3'(a)));
            end
            tick();
        end
        reset_n = 1'b1;
    endtask

    task automatic test_data_dir();
        logic [31:0] d;
        wr(3'd1, 32'h0000_00F0);
        wr(3'd0, 32'hFFFF_FF3C);
        in_port = 8'h0F;
        ticks(3);
        rd(3'd0, d);
        checks++; if (d !== 32'h3F || d !== m_read(3'd0)) begin errors++; $display("FAIL data_read got %h want 0000003f", d); end
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL data_out_port got %h want 3c", out_port); end
        checks++; if (oe_port !== 8'hF0) begin errors++; $display("FAIL data_oe_port got %h want f0", oe_port); end
    endtask

    task automatic test_outset_outclr();
        logic [31:0] d;
        wr(3'd0, 32'h3C);
        wr(3'd4, 32'h01);
        checks++; if (out_port !== 8'h3D || out_port !== m_dout) begin errors++; $display("FAIL outset got %h want 3d", out_port); end
        rd(3'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL outset_read got %h want 0", d); end
        tick();
        wr(3'd5, 32'h04);
        checks++; if (out_port !== 8'h39 || out_port !== m_dout) begin errors++; $display("FAIL outclr got %h want 39", out_port); end
        rd(3'd5, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL outclr_read got %h want 0", d); end
        tick();
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        in_port = 8'h00;
        ticks(5);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h02);
        in_port = 8'h02;
        ticks(2);
        rd(3'd3, d);
        checks++; if (d !== 32'h0 || d !== m_read(3'd3)) begin errors++; $display("FAIL edge_early got %h want 0", d); end
        tick();
        rd(3'd3, d);
        checks++; if (d !== 32'h02 || d !== m_read(3'd3)) begin errors++; $display("FAIL edge_cap got %h want 02", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq got %b want 1", irq); end
        tick();
        wr(3'd3, 32'h02);
        checks++; if (irq !== 1'b0 || irq !== m_irq()) begin errors++; $display("FAIL edge_irq_clear got %b want 0", irq); end
    endtask

    task automatic test_clear_collision();
        logic [31:0] d;
        in_port = 8'h00;
        ticks(5);
        wr(3'd3, 32'hFF);
        in_port = 8'h02;
        ticks(2);
        wr(3'd3, 32'h02);
        rd(3'd3, d);
        checks++; if (d !== 32'h02 || d !== m_read(3'd3)) begin errors++; $display("FAIL collision_cap got %h want 02", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq got %b want 1", irq); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        in_port = 8'h00;
        ticks(5);
        wr(3'd2, 32'hFF);
        in_port = 8'hFF;
        ticks(4);
        rd(3'd3, d);
        checks++; if (d !== 32'hFF || d !== m_read(3'd3)) begin errors++; $display("FAIL midreset_pre_cap got %h want ff", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL midreset_pre_irq got %b want 1", irq); end
        reset_n = 1'b0;
        model_reset();
        tick();
        reset_n = 1'b1;
        rd(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_cap got %h want 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b want 0", irq); end
        checks++; if (out_port !== RV) begin errors++; $display("FAIL midreset_out got %h want %h", out_port, RV); end
        wr(3'd2, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            rd(3'd3, d);
            checks++;
            if (d !== 32'h0 || irq !== 1'b0) begin
                errors++; $display("FAIL midreset_spurious cycle %0d got cap %h irq %b want 0 0", i, d, irq);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int op;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            op = $urandom_range(0, 3);
            if (op == 0) begin
                wr(3'($urandom_range(0, 7)), $urandom);
            end else if (op == 1) begin
                address = 3'($urandom_range(0, 7));
                rd(address, d);
                checks++;
                if (d !== m_read(address)) begin
                    errors++; $display("FAIL rand_read addr %0d cycle %0d got %h want %h", address, i, d, m_read(address));
                end
                tick();
            end else if (op == 2) begin
                address    = 3'($urandom_range(0, 7));
                chipselect = 1'b0;
                write_n    = 1'($urandom);
                #1;
                checks++;
                if (readdata !== 32'h0) begin errors++; $display("FAIL rand_idle_read got %h want 0", readdata); end
                tick();
                write_n = 1'b1;
            end else begin
                tick();
            end
            checks++;
            if (out_port !== m_dout || oe_port !== m_dir || irq !== m_irq()) begin
                errors++;
                $display("FAIL rand_outputs cycle %0d got out %h oe %h irq %b want %h %h %b",
                         i, out_port, oe_port, irq, m_dout, m_dir, m_irq());
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        model_reset();
        test_reset();
        test_data_dir();
        test_outset_outclr();
        test_edge_irq();
        test_clear_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_ctrl_gen2.md
PIO_CTRL_GEN2 -- requirements
Module: pio_ctrl_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning port width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the reset value of the output data register.
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, meaning capture mode: 0 = rising, 1 = falling, 2 = any edge.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth, legal range 2..4.
REQ-005 clk  input  1  sole clock; all registers on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data; bits above DATA_WIDTH ignored.
REQ-011 readdata  output  32  read data; zero-extended above DATA_WIDTH.
REQ-012 in_port  input  DATA_WIDTH  asynchronous pin inputs.
REQ-013 out_port  output  DATA_WIDTH  registered output data.
REQ-014 oe_port  output  DATA_WIDTH  per-bit output enable (1 = drive).
REQ-015 irq  output  1  level interrupt, active-high.

Function
REQ-016 The register map SHALL be: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP, 4 OUTSET, 5 OUTCLR; addresses 6-7 read 0 and ignore writes.
REQ-017 A write SHALL occur on the clock edge where chipselect=1 and write_n=0; no wait states.
REQ-018 Reads SHALL be combinational, zero latency, from current register state whenever chipselect=1 and write_n=1; readdata SHALL be 0 otherwise.
REQ-019 DATA read SHALL return, per bit, data_out where DIR=1, else the synchronised input.
REQ-020 DATA write SHALL load data_out with writedata[DATA_WIDTH-1:0].
REQ-021 OUTSET write SHALL set data_out bits where writedata=1; OUTCLR write SHALL clear them; both read back 0.
REQ-022 DIR and IRQ_MASK SHALL be plain read/write registers; oe_port SHALL equal DIR; out_port SHALL equal data_out.
REQ-023 in_port SHALL pass through a SYNC_STAGES flop chain; a pin change is visible on DATA reads exactly SYNC_STAGES cycles later.
REQ-024 Edge detection SHALL compare the last synchroniser stage with one further delayed copy; the EDGE_CAP bit SHALL set SYNC_STAGES+1 cycles after the pin change, regardless of DIR or IRQ_MASK.
REQ-025 EDGE_CAP bits SHALL be sticky, cleared only by writing 1 to the bit at address 3; writing 0 has no effect.
REQ-026 If a clear and a new edge hit the same bit in the same cycle, the set SHALL win.
REQ-027 irq SHALL equal OR(EDGE_CAP & IRQ_MASK), combinational from registers, no extra latency.
REQ-028 A pulse shorter than one clk period MAY be missed; no requirement is placed on it.

Reset
REQ-029 On reset_n=0, data_out SHALL = RESET_VALUE, and DIR, IRQ_MASK, EDGE_CAP, the synchroniser and the delay flops SHALL = 0.
REQ-030 Consequently oe_port=0, irq=0 and out_port=RESET_VALUE during and immediately after reset.
REQ-031 Reset asserted mid-operation SHALL discard pending edges; the first post-reset cycle SHALL NOT produce a spurious edge from the reset-to-pin transition until the pipeline has filled.

Structure
REQ-032 Register address constants and EDGE_TYPE encodings SHALL live in a shared package pio_gen2_pkg.
REQ-033 The synchroniser SHALL be a separate sub-module pio_sync_chain (parameters WIDTH, STAGES).
REQ-034 The top level SHALL contain the register file, edge detector and read mux only.

Verification
REQ-035 Reset: hold reset_n=0, RESET_VALUE=8'hA5 -> out_port=8'hA5, oe_port=0, irq=0, all reads except DATA return 0.
REQ-036 Write DIR=8'hF0, DATA=8'h3C, in_port=8'h0F -> DATA read 8'h3F; out_port=8'h3C; oe_port=8'hF0.
REQ-037 With DATA=8'h3C, write OUTSET 8'h01 then OUTCLR 8'h04 -> out_port 8'h3D then 8'h39; reads of addresses 4 and 5 return 0.
REQ-038 EDGE_TYPE=0, IRQ_MASK=8'h02; in_port bit1 0->1 -> EDGE_CAP=8'h02 after exactly 3 cycles and irq=1; write 8'h02 to EDGE_CAP -> irq=0 next cycle.
REQ-039 A clear of bit1 in the same cycle as a new bit1 edge -> EDGE_CAP bit1 stays 1.
REQ-040 Assert reset_n for one cycle with EDGE_CAP=8'hFF -> EDGE_CAP=0 and irq=0; with in_port steady 8'hFF, no edge is captured after release.
